// File: rtl/dummy_ether_tx.sv
// dummy_ether_tx: sends a fixed Ethernet frame with CRC-32 FCS over a 2-bit RMII-style bus on each trigger
module dummy_ether_tx #(
  parameter logic [47:0] DEST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int PAYLOAD_BYTES = 46
) (
  input logic clk_in,
  input logic rst_in,
  input logic trigger_in,
  output logic axiov,
  output logic [1:0] axiod
);
  localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, DATA = 3'd2, FCS = 3'd3, GAP = 3'd4;
  localparam logic [111:0] HDR = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [12:0] DLAST = 13'((14 + PAYLOAD_BYTES) * 4 - 1);
  logic [2:0] state;
  logic [12:0] cnt;
  logic [31:0] crc, crc_next;
  logic [10:0] bi;
  logic [7:0] byte_val;
  logic [1:0] data_dibit, fcs_dibit;
  always_comb begin
    bi = cnt[12:2];
    byte_val = bi < 11'd14 ? 8'(HDR >> {4'(11'd13 - bi), 3'b000}) : 8'(bi - 11'd14);
    data_dibit = 2'(byte_val >> {cnt[1:0], 1'b0});
    fcs_dibit = 2'(~crc >> {cnt[3:0], 1'b0});
    crc_next = crc;
    for (int i = 0; i < 2; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data_dibit[i]) ? 32'hEDB88320 : 32'h0);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      crc <= '1;
      axiov <= 1'b0;
      axiod <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          axiov <= trigger_in;
          axiod <= trigger_in ? 2'b01 : 2'b00;
          crc <= '1;
          cnt <= 13'd1;
          state <= trigger_in ? PREAMBLE : IDLE;
        end
        PREAMBLE: begin
          axiov <= 1'b1;
          axiod <= cnt == 13'd31 ? 2'b11 : 2'b01;
          cnt <= cnt == 13'd31 ? 13'd0 : cnt + 13'd1;
          state <= cnt == 13'd31 ? DATA : PREAMBLE;
        end
        DATA: begin
          axiov <= 1'b1;
          axiod <= data_dibit;
          crc <= crc_next;
          cnt <= cnt == DLAST ? 13'd0 : cnt + 13'd1;
          state <= cnt == DLAST ? FCS : DATA;
        end
        FCS: begin
          axiov <= 1'b1;
          axiod <= fcs_dibit;
          cnt <= cnt == 13'd15 ? 13'd0 : cnt + 13'd1;
          state <= cnt == 13'd15 ? GAP : FCS;
        end
        GAP: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          cnt <= cnt == 13'd47 ? 13'd0 : cnt + 13'd1;
          state <= cnt == 13'd47 ? IDLE : GAP;
        end
        default: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dummy_ether_tx.sv
// tb_dummy_ether_tx: randomized directed checks of dummy_ether_tx against a byte-level frame model
module tb_dummy_ether_tx;
  localparam logic [47:0] DEST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC = 48'h69_69_5A_06_54_91;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int PAY = 46;
  localparam int NDIB = (8 + 14 + PAY + 4) * 4;
  logic clk_in = 1'b0;
  logic rst_in, trigger_in, axiov;
  logic [1:0] axiod;
  int total = 0, bad = 0;
  logic [1:0] exp_q[$], got[$], first_q[$];
  logic [31:0] model_fcs;
  dummy_ether_tx #(.DEST_MAC(DEST), .SRC_MAC(SRC), .ETHERTYPE(ETYPE), .PAYLOAD_BYTES(PAY)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trigger_in(trigger_in), .axiov(axiov), .axiod(axiod)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic build_model;
    logic [7:0] fr[$];
    logic [47:0] d, s;
    logic [31:0] c;
    d = DEST;
    s = SRC;
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(d[47 - 8 * i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(s[47 - 8 * i -: 8]);
    fr.push_back(ETYPE[15:8]);
    fr.push_back(ETYPE[7:0]);
    for (int i = 0; i < PAY; i++) fr.push_back(8'(i));
    c = 32'hFFFFFFFF;
    for (int i = 8; i < fr.size(); i++) begin
      c ^= {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    model_fcs = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(model_fcs[8 * i +: 8]);
    exp_q.delete();
    foreach (fr[i]) for (int j = 0; j < 4; j++) exp_q.push_back(fr[i][2 * j +: 2]);
  endtask
  task automatic start(input int idle);
    trigger_in = 1'b0;
    for (int i = 0; i < idle; i++) begin
      chk("idle_axiov", axiov, 0);
      chk("idle_axiod", axiod, 0);
      tick;
    end
    trigger_in = 1'b1;
    tick;
  endtask
  task automatic check_frame(input bit noisy, input int rst_k, input bit last_trig);
    logic [31:0] cap_fcs, r, rr;
    got.delete();
    for (int k = 0; k < NDIB; k++) begin
      chk("frame_axiov", axiov, 1);
      chk($sformatf("dibit%0d", k), axiod, exp_q[k]);
      got.push_back(axiod);
      trigger_in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == rst_k) begin
        rst_in = 1'b1;
        tick;
        chk("abort_axiov", axiov, 0);
        chk("abort_axiod", axiod, 0);
        rst_in = 1'b0;
        trigger_in = 1'b0;
        return;
      end
      tick;
    end
    for (int g = 0; g < 48; g++) begin
      chk("gap_axiov", axiov, 0);
      chk("gap_axiod", axiod, 0);
      trigger_in = g == 47 ? last_trig : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      tick;
    end
    for (int j = 0; j < 16; j++) cap_fcs[2 * j +: 2] = got[NDIB - 16 + j];
    chk("fcs", cap_fcs, model_fcs);
    r = 32'hFFFFFFFF;
    for (int k = 32; k < NDIB; k++)
      for (int b = 0; b < 2; b++) r = (r[0] ^ got[k][b]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    rr = {<<{r}};
    chk("residue", rr, 32'hC704DD7B);
  endtask
  task automatic same_as_first(input string tag);
    int diff;
    diff = (got.size() == first_q.size()) ? 0 : 1;
    foreach (got[i]) if (i < first_q.size() && got[i] !== first_q[i]) diff++;
    chk(tag, diff, 0);
  endtask
  initial begin
    build_model();
    rst_in = 1'b1;
    trigger_in = 1'b1;
    repeat (3) tick;
    chk("reset_axiov", axiov, 0);
    chk("reset_axiod", axiod, 0);
    rst_in = 1'b0;
    trigger_in = 1'b0;
    start(10);
    check_frame(1'b0, -1, 1'b0);
    first_q = got;
    start(63);
    check_frame(1'b0, -1, 1'b0);
    same_as_first("second_frame");
    start($urandom_range(3, 20));
    check_frame(1'b1, -1, 1'b0);
    same_as_first("noisy_frame");
    start($urandom_range(3, 20));
    check_frame(1'b0, -1, 1'b1);
    check_frame(1'b0, -1, 1'b0);
    same_as_first("back_to_back");
    start($urandom_range(3, 20));
    check_frame(1'b1, 100, 1'b0);
    start($urandom_range(3, 20));
    check_frame(1'b0, -1, 1'b0);
    same_as_first("after_abort");
    start(20);
    trigger_in = 1'b0;
    tick;
    chk("trigger_stops", axiov, 1);
    rst_in = 1'b1;
    trigger_in = 1'b1;
    tick;
    chk("rst_priority", axiov, 0);
    rst_in = 1'b0;
    trigger_in = 1'b0;
    start(5);
    check_frame(1'b0, -1, 1'b0);
    same_as_first("final_frame");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
